// File: rtl/alu_core_pipe.sv
// alu_core_pipe: two-stage pipelined ALU core with valid/ready handshakes.
// S1 captures operands, opcode and the error class (framing, CRC-4, opcode).
// S2 computes the result, the flags and the CRC-3 protected status byte.
module alu_core_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter bit          CHK_CRC = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [7:0]        CTL_in,
    input  logic              in_err_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] C,
    output logic [7:0]        CTL_out
);
    localparam logic [7:0] ERR_DATA = 8'b11001001;
    localparam logic [7:0] ERR_CRC  = 8'b10100101;
    localparam logic [7:0] ERR_OP   = 8'b10010011;

    localparam int CRC4_LEN = 2 * int'(DATA_W) + 4;
    localparam int CRC3_LEN = int'(DATA_W) + 5;

    // Serial MSB-first CRC-4, polynomial x^4+x+1, init 0
    function automatic logic [3:0] crc4_calc(input logic [CRC4_LEN-1:0] msg);
        logic [3:0] crc;
        logic       fb;
        crc = 4'b0000;
        for (int i = CRC4_LEN - 1; i >= 0; i--) begin
            fb  = crc[3] ^ msg[i];
            crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return crc;
    endfunction

    // Serial MSB-first CRC-3, polynomial x^3+x+1, init 0
    function automatic logic [2:0] crc3_calc(input logic [CRC3_LEN-1:0] msg);
        logic [2:0] crc;
        logic       fb;
        crc = 3'b000;
        for (int i = CRC3_LEN - 1; i >= 0; i--) begin
            fb  = crc[2] ^ msg[i];
            crc = {crc[1:0], 1'b0} ^ {1'b0, fb, fb};
        end
        return crc;
    endfunction

    // Stage registers
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    logic [2:0]        r_s1_op;
    logic              r_s1_err;
    logic [7:0]        r_s1_err_code;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_c;
    logic [7:0]        r_ctl;

    // Handshake and capture-side wires
    logic              w_s2_ready;
    logic              w_s1_load;
    logic              w_s2_load;
    logic [2:0]        w_op;
    logic              w_crc_ok;
    logic              w_op_ok;
    logic              w_err;
    logic [7:0]        w_err_code;
    logic              w_unused_ctl7;

    // Compute-side wires
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_res;
    logic              w_carry;
    logic              w_ovf;
    logic              w_zero;
    logic              w_neg;
    logic [2:0]        w_crc3;
    logic [DATA_W-1:0] w_c_next;
    logic [7:0]        w_ctl_next;

    // Bit 7 of the control byte is a fixed framing zero and carries no information
    assign w_unused_ctl7 = CTL_in[7];

    assign w_s2_ready = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;
    assign w_s1_load  = in_valid && in_ready;
    assign w_s2_load  = r_s1_valid && w_s2_ready;

    assign w_op     = CTL_in[6:4];
    assign w_crc_ok = (crc4_calc({B, A, 1'b1, w_op}) == CTL_in[3:0]);
    assign w_op_ok  = (w_op == 3'b000) || (w_op == 3'b001) ||
                      (w_op == 3'b100) || (w_op == 3'b101);

    // Error classification in priority order: framing, CRC, opcode
    always_comb begin
        w_err      = 1'b1;
        w_err_code = 8'h00;
        if (in_err_data) begin
            w_err_code = ERR_DATA;
        end else if (CHK_CRC && !w_crc_ok) begin
            w_err_code = ERR_CRC;
        end else if (!w_op_ok) begin
            w_err_code = ERR_OP;
        end else begin
            w_err = 1'b0;
        end
    end

    // Execute the stage-1 operation and build the status byte
    always_comb begin
        w_sum   = {1'b0, r_s1_a} + {1'b0, r_s1_b};
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_s1_op)
            3'b000: w_res = r_s1_a & r_s1_b;
            3'b001: w_res = r_s1_a | r_s1_b;
            3'b100: begin
                w_res   = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
                w_ovf   = (r_s1_a[DATA_W-1] == r_s1_b[DATA_W-1]) &&
                          (w_res[DATA_W-1] != r_s1_a[DATA_W-1]);
            end
            3'b101: begin
                w_res   = r_s1_a - r_s1_b;
                w_carry = (r_s1_a < r_s1_b);
                w_ovf   = (r_s1_a[DATA_W-1] != r_s1_b[DATA_W-1]) &&
                          (w_res[DATA_W-1] != r_s1_a[DATA_W-1]);
            end
            default: w_res = '0;
        endcase
        w_zero = (w_res == '0);
        w_neg  = w_res[DATA_W-1];
        w_crc3 = crc3_calc({w_res, 1'b0, w_carry, w_ovf, w_zero, w_neg});
        if (r_s1_err) begin
            w_c_next   = '0;
            w_ctl_next = r_s1_err_code;
        end else begin
            w_c_next   = w_res;
            w_ctl_next = {1'b0, w_carry, w_ovf, w_zero, w_neg, w_crc3};
        end
    end

    // Stage 1: capture operands and error class on an input handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid    <= 1'b1;
            r_s1_a        <= A;
            r_s1_b        <= B;
            r_s1_op       <= w_op;
            r_s1_err      <= w_err;
            r_s1_err_code <= w_err_code;
        end else if (w_s2_ready) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: register result and status; hold while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_c        <= '0;
            r_ctl      <= 8'hFF;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_c        <= w_c_next;
            r_ctl      <= w_ctl_next;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign C         = r_c;
    assign CTL_out   = r_ctl;

endmodule

// File: tb/tb_alu_core_pipe.sv
// Directed testbench for alu_core_pipe: a 32-bit CRC-checking instance and an
// 8-bit instance with CRC checking disabled.
module tb_alu_core_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, in_err, out_valid, out_ready;
    logic [31:0] a_in, b_in, c_out;
    logic [7:0]  ctl_in, ctl_out;

    logic        v8, r8, e8, ov8, or8;
    logic [7:0]  a8, b8, c8, ci8, co8;

    int n_checks = 0;
    int n_fail   = 0;

    alu_core_pipe #(.DATA_W(32), .CHK_CRC(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_in), .B(b_in), .CTL_in(ctl_in), .in_err_data(in_err),
        .out_valid(out_valid), .out_ready(out_ready), .C(c_out), .CTL_out(ctl_out)
    );

    alu_core_pipe #(.DATA_W(8), .CHK_CRC(1'b0)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
        .A(a8), .B(b8), .CTL_in(ci8), .in_err_data(e8),
        .out_valid(ov8), .out_ready(or8), .C(c8), .CTL_out(co8)
    );

    // Reference CRCs by polynomial long division of msg * x^k
    function automatic logic [3:0] m_crc4(input logic [127:0] msg, input int n);
        logic [127:0] r;
        r = msg << 4;
        for (int i = n + 3; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [2:0] m_crc3(input logic [127:0] msg, input int n);
        logic [127:0] r;
        r = msg << 3;
        for (int i = n + 2; i >= 3; i--)
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    function automatic logic [7:0] mk_ctl32(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        return {1'b0, op, m_crc4(128'({b, a, 1'b1, op}), 68)};
    endfunction

    function automatic logic [7:0] mk_ctl8(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        return {1'b0, op, m_crc4(128'({b, a, 1'b1, op}), 20)};
    endfunction

    // flags = {carry, overflow, zero, negative}
    function automatic logic [7:0] st32(input logic [31:0] c, input logic [3:0] flags);
        return {1'b0, flags, m_crc3(128'({c, 1'b0, flags}), 37)};
    endfunction

    function automatic logic [7:0] st8(input logic [7:0] c, input logic [3:0] flags);
        return {1'b0, flags, m_crc3(128'({c, 1'b0, flags}), 13)};
    endfunction

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl,
                         input logic e);
        @(negedge clk);
        a_in = a; b_in = b; ctl_in = ctl; in_err = e; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ctl);
        @(negedge clk);
        a8 = a; b8 = b; ci8 = ctl; e8 = 1'b0; v8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; or8 = 1'b1;
        a_in = 32'd1; b_in = 32'd2; ctl_in = mk_ctl32(3'b100, 32'd1, 32'd2);
        in_err = 1'b0; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (ctl_out !== 8'hFF) begin n_fail++; $display("FAIL reset_ctl: got %h want ff", ctl_out); end
        n_checks++; if (c_out !== 32'h0) begin n_fail++; $display("FAIL reset_c: got %h want 0", c_out); end
        rst = 1'b0;
        a_in = 32'd3; b_in = 32'd4; ctl_in = mk_ctl32(3'b100, 32'd3, 32'd4);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: got %b want 0", out_valid); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_2: got %b want 1", out_valid); end
        n_checks++; if (c_out !== 32'd7) begin n_fail++; $display("FAIL first_c: got %h want 7", c_out); end
        n_checks++; if (ctl_out !== st32(32'd7, 4'b0000)) begin n_fail++; $display("FAIL first_ctl: got %h want %h", ctl_out, st32(32'd7, 4'b0000)); end
        // Reset with two frames in flight must discard both
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || ctl_out !== 8'hFF) begin n_fail++; $display("FAIL midreset: got v=%b ctl=%h want v=0 ctl=ff", out_valid, ctl_out); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_flush: got %b want 0", out_valid); end
    endtask

    task automatic test_add_overflow();
        run32(32'h7FFF_FFFF, 32'h1, mk_ctl32(3'b100, 32'h7FFF_FFFF, 32'h1), 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
        n_checks++; if (c_out !== 32'h8000_0000) begin n_fail++; $display("FAIL add_c: got %h want 80000000", c_out); end
        n_checks++; if (ctl_out !== st32(32'h8000_0000, 4'b0101)) begin n_fail++; $display("FAIL add_ctl: got %h want %h", ctl_out, st32(32'h8000_0000, 4'b0101)); end
    endtask

    task automatic test_sub();
        run32(32'd5, 32'd5, mk_ctl32(3'b101, 32'd5, 32'd5), 1'b0);
        n_checks++; if (c_out !== 32'h0) begin n_fail++; $display("FAIL sub_zero_c: got %h want 0", c_out); end
        n_checks++; if (ctl_out !== st32(32'h0, 4'b0010)) begin n_fail++; $display("FAIL sub_zero_ctl: got %h want %h", ctl_out, st32(32'h0, 4'b0010)); end
        run32(32'd0, 32'd1, mk_ctl32(3'b101, 32'd0, 32'd1), 1'b0);
        n_checks++; if (c_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub_borrow_c: got %h want ffffffff", c_out); end
        n_checks++; if (ctl_out !== st32(32'hFFFF_FFFF, 4'b1001)) begin n_fail++; $display("FAIL sub_borrow_ctl: got %h want %h", ctl_out, st32(32'hFFFF_FFFF, 4'b1001)); end
    endtask

    task automatic test_logic();
        run32(32'hF0F0_1234, 32'h0FF0_FF00, mk_ctl32(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00), 1'b0);
        n_checks++; if (c_out !== 32'h00F0_1200) begin n_fail++; $display("FAIL and_c: got %h want 00f01200", c_out); end
        n_checks++; if (ctl_out !== st32(32'h00F0_1200, 4'b0000)) begin n_fail++; $display("FAIL and_ctl: got %h want %h", ctl_out, st32(32'h00F0_1200, 4'b0000)); end
        run32(32'h8000_0000, 32'h0000_00F1, mk_ctl32(3'b001, 32'h8000_0000, 32'h0000_00F1), 1'b0);
        n_checks++; if (c_out !== 32'h8000_00F1) begin n_fail++; $display("FAIL or_c: got %h want 800000f1", c_out); end
        n_checks++; if (ctl_out !== st32(32'h8000_00F1, 4'b0001)) begin n_fail++; $display("FAIL or_ctl: got %h want %h", ctl_out, st32(32'h8000_00F1, 4'b0001)); end
    endtask

    task automatic test_errors();
        run32(32'd9, 32'd3, mk_ctl32(3'b100, 32'd9, 32'd3) ^ 8'h01, 1'b0);
        n_checks++; if (c_out !== 32'h0) begin n_fail++; $display("FAIL errcrc_c: got %h want 0", c_out); end
        n_checks++; if (ctl_out !== 8'b10100101) begin n_fail++; $display("FAIL errcrc_ctl: got %h want a5", ctl_out); end
        run32(32'd9, 32'd3, mk_ctl32(3'b010, 32'd9, 32'd3), 1'b0);
        n_checks++; if (c_out !== 32'h0) begin n_fail++; $display("FAIL errop_c: got %h want 0", c_out); end
        n_checks++; if (ctl_out !== 8'b10010011) begin n_fail++; $display("FAIL errop_ctl: got %h want 93", ctl_out); end
        run32(32'd9, 32'd3, mk_ctl32(3'b100, 32'd9, 32'd3) ^ 8'h01, 1'b1);
        n_checks++; if (c_out !== 32'h0) begin n_fail++; $display("FAIL errdata_c: got %h want 0", c_out); end
        n_checks++; if (ctl_out !== 8'b11001001) begin n_fail++; $display("FAIL errdata_ctl: got %h want c9", ctl_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] fa [5];
        logic [31:0] ec [5];
        logic [3:0]  ef [5];
        logic [31:0] bb;
        logic [31:0] hc;
        logic [7:0]  hs;
        logic        held, saw_stall, ih, oh, exp_rdy;
        int          sent, recv, occ;
        bb = 32'hF0F0_FF00;
        fa = '{32'h0F0F_00FF, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1234_5678, 32'hF000_000F};
        ec = '{32'h0000_0000, 32'hF0F0_FF00, 32'h8000_0000, 32'h1030_5600, 32'hF000_0000};
        ef = '{4'b0010, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        sent = 0; recv = 0; occ = 0; held = 1'b0; saw_stall = 1'b0; hc = '0; hs = '0;
        for (int cyc = 0; cyc < 60 && recv < 5; cyc++) begin
            @(negedge clk);
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || c_out !== hc || ctl_out !== hs) begin
                    n_fail++;
                    $display("FAIL b2b_hold: got v=%b c=%h ctl=%h want v=1 c=%h ctl=%h", out_valid, c_out, ctl_out, hc, hs);
                end
            end
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 5);
            if (sent < 5) begin
                a_in = fa[sent]; b_in = bb; in_err = 1'b0;
                ctl_in = mk_ctl32(3'b000, fa[sent], bb);
            end
            #1;
            exp_rdy = (occ < 2) || out_ready;
            n_checks++;
            if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_in_ready: got %b want %b", in_ready, exp_rdy); end
            if (in_ready === 1'b0) saw_stall = 1'b1;
            ih = in_valid && in_ready;
            oh = out_valid && out_ready;
            if (oh) begin
                n_checks++;
                if (c_out !== ec[recv] || ctl_out !== st32(ec[recv], ef[recv])) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: got c=%h ctl=%h want c=%h ctl=%h", recv, c_out, ctl_out, ec[recv], st32(ec[recv], ef[recv]));
                end
                recv++;
            end
            held = out_valid && !out_ready;
            hc = c_out; hs = ctl_out;
            if (ih) sent++;
            occ = occ + int'(ih) - int'(oh);
        end
        n_checks++; if (recv != 5) begin n_fail++; $display("FAIL b2b_count: got %0d want 5", recv); end
        n_checks++; if (saw_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got %b want 1", saw_stall); end
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_param8();
        run8(8'hFF, 8'h01, mk_ctl8(3'b100, 8'hFF, 8'h01) ^ 8'h06);
        n_checks++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL p8_valid: got %b want 1", ov8); end
        n_checks++; if (c8 !== 8'h00) begin n_fail++; $display("FAIL p8_add_c: got %h want 00", c8); end
        n_checks++; if (co8 !== st8(8'h00, 4'b1010)) begin n_fail++; $display("FAIL p8_add_ctl: got %h want %h", co8, st8(8'h00, 4'b1010)); end
        run8(8'h80, 8'h01, mk_ctl8(3'b101, 8'h80, 8'h01) ^ 8'h0F);
        n_checks++; if (c8 !== 8'h7F) begin n_fail++; $display("FAIL p8_sub_c: got %h want 7f", c8); end
        n_checks++; if (co8 !== st8(8'h7F, 4'b0100)) begin n_fail++; $display("FAIL p8_sub_ctl: got %h want %h", co8, st8(8'h7F, 4'b0100)); end
        run8(8'h12, 8'h34, mk_ctl8(3'b011, 8'h12, 8'h34) ^ 8'h03);
        n_checks++; if (c8 !== 8'h00 || co8 !== 8'b10010011) begin n_fail++; $display("FAIL p8_errop: got c=%h ctl=%h want c=00 ctl=93", c8, co8); end
    endtask

    initial begin
        v8 = 1'b0; e8 = 1'b0; a8 = '0; b8 = '0; ci8 = '0; or8 = 1'b1;
        in_valid = 1'b0; in_err = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; ctl_in = '0; rst = 1'b1;
        test_reset();
        test_add_overflow();
        test_sub();
        test_logic();
        test_errors();
        test_back_to_back();
        test_param8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
